// File: rtl/adc_sample_filter_pkg.sv
// -----------------------------------------------------------------------------
// adc_sample_filter_pkg
//   Shared constants for the ADC sample path. ADC_SPI_In and its consumers
//   use the same data width and the same filter defaults.
//   Helper: log2_depth_is_legal() reports whether an averaging window exponent
//   is in the supported 1..6 range.
// -----------------------------------------------------------------------------
package adc_sample_filter_pkg;

    localparam int ADC_DATA_WIDTH          = 16;
    localparam int ADC_LOG2_DEPTH_DEFAULT  = 3;
    localparam int ADC_HYST_THRESH_DEFAULT = 4;

    localparam int ADC_LOG2_DEPTH_MIN = 1;
    localparam int ADC_LOG2_DEPTH_MAX = 6;

    function automatic bit log2_depth_is_legal(input int log2_depth);
        return (log2_depth >= ADC_LOG2_DEPTH_MIN) && (log2_depth <= ADC_LOG2_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/adc_sample_filter_ring_buffer.sv
// -----------------------------------------------------------------------------
// sample_ring_buffer
//   2^ADDR_WIDTH x DATA_WIDTH sample store for the boxcar window.
//   One write port and one read port with a registered read, so it maps onto
//   block or distributed RAM. Contents are not reset.
// Ports:
//   clock    in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module sample_ring_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_sample_filter.sv
// -----------------------------------------------------------------------------
// adc_sample_filter
//   Boxcar average over the last 2^LOG2_DEPTH ADC words, producing a steady
//   control value for the pitch/harmonic CV paths. A new sample is taken on
//   each rising edge of data_received and goes through a 4-stage pipeline:
//     C0 accept/latch, C1 read oldest entry, C2 update sum and write the new
//     entry, C3 output stage (filtered_valid is visible in the clock after C3).
//   LOG2_DEPTH must lie in 1..6.
//
//   Build option: define ADC_FILTER_HYSTERESIS_EN to hold the output until
//   the average moves by more than HYST_THRESH LSBs (the first primed output
//   always updates). Without it every primed sample updates the output.
//
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   data_in         in   ADC word, stable while data_received is high
//   data_received   in   level; a 0->1 transition marks a new sample
//   filtered_out    out  averaged (optionally hysteresis-held) value
//   filtered_valid  out  one-clock pulse when filtered_out is written
//   primed          out  high once the window holds a full set of samples
//   overrun         out  sticky: an edge arrived while the pipeline was busy
// -----------------------------------------------------------------------------
module adc_sample_filter
    import adc_sample_filter_pkg::*;
#(
    parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
    parameter int LOG2_DEPTH  = ADC_LOG2_DEPTH_DEFAULT,
    parameter int HYST_THRESH = ADC_HYST_THRESH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_received,
    output logic [DATA_WIDTH-1:0] filtered_out,
    output logic                  filtered_valid,
    output logic                  primed,
    output logic                  overrun
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] FILL_LAST = (LOG2_DEPTH + 1)'(DEPTH - 1);

    // Edge detect and pipeline occupancy
    logic                  dr_reg;
    logic                  s1_reg;
    logic                  s2_reg;
    logic                  s3_reg;
    logic [DATA_WIDTH-1:0] sample_reg;
    logic                  overrun_reg;
    logic                  rise;
    logic                  blocking;
    logic                  accept;
    logic                  collide;

    // Window state
    logic [LOG2_DEPTH-1:0] wr_ptr_reg;
    logic [LOG2_DEPTH:0]   fill_reg;
    logic [SUM_W-1:0]      sum_reg;
    logic                  primed_reg;
    logic [DATA_WIDTH-1:0] oldest;

    // Output stage
    logic [DATA_WIDTH-1:0] filtered_out_reg;
    logic                  filtered_valid_reg;
    logic [DATA_WIDTH-1:0] avg;
    logic                  update;

    assign rise = data_received & ~dr_reg;
    // Only C1/C2 block a new sample: an edge landing on C3 can start C0 while
    // the previous sample is just writing its output.
    assign blocking = s1_reg | s2_reg;
    assign accept   = rise & ~blocking;
    assign collide  = rise & blocking;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dr_reg      <= 1'b0;
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            s3_reg      <= 1'b0;
            sample_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            dr_reg <= data_received;
            s1_reg <= accept;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
            if (accept) begin
                sample_reg <= data_in;
            end
            if (collide) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // C1 reads the entry that C2 will overwrite: that is the oldest sample.
    sample_ring_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (LOG2_DEPTH)
    ) u_ring (
        .clock   (clock),
        .wr_en   (s2_reg),
        .wr_addr (wr_ptr_reg),
        .wr_data (sample_reg),
        .rd_en   (s1_reg),
        .rd_addr (wr_ptr_reg),
        .rd_data (oldest)
    );

    // Until primed the RAM holds stale data, so nothing is subtracted. The
    // add may wrap transiently; the subtract brings the modular sum back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_reg    <= '0;
            wr_ptr_reg <= '0;
            fill_reg   <= '0;
            primed_reg <= 1'b0;
        end else if (s2_reg) begin
            sum_reg    <= sum_reg + SUM_W'(sample_reg) - (primed_reg ? SUM_W'(oldest) : '0);
            wr_ptr_reg <= wr_ptr_reg + LOG2_DEPTH'(1);
            if (fill_reg != FILL_FULL) begin
                fill_reg <= fill_reg + (LOG2_DEPTH + 1)'(1);
            end
            if (fill_reg == FILL_LAST) begin
                primed_reg <= 1'b1;
            end
        end
    end

    assign avg = sum_reg[SUM_W-1:LOG2_DEPTH];

`ifdef ADC_FILTER_HYSTERESIS_EN
    logic                  has_output_reg;
    logic [DATA_WIDTH-1:0] step;
    logic                  big_step;

    assign step     = (avg >= filtered_out_reg) ? (avg - filtered_out_reg) : (filtered_out_reg - avg);
    assign big_step = 32'(step) > 32'(HYST_THRESH);
    assign update   = primed_reg & (~has_output_reg | big_step);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            has_output_reg <= 1'b0;
        end else if (s3_reg && update) begin
            has_output_reg <= 1'b1;
        end
    end
`else
    // The threshold has no effect when every primed sample updates.
    logic [31:0] unused_hyst_thresh;
    assign unused_hyst_thresh = 32'(HYST_THRESH);
    assign update = primed_reg;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filtered_out_reg   <= '0;
            filtered_valid_reg <= 1'b0;
        end else begin
            filtered_valid_reg <= 1'b0;
            if (s3_reg && update) begin
                filtered_out_reg   <= avg;
                filtered_valid_reg <= 1'b1;
            end
        end
    end

    assign filtered_out   = filtered_out_reg;
    assign filtered_valid = filtered_valid_reg;
    assign primed         = primed_reg;
    assign overrun        = overrun_reg;

endmodule
